// File: rtl/display_page_arbiter_if.sv
// Requester/display bus for display_page_arbiter: page handshake, freeze, and the displayed page.
interface display_page_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DIGIT_BITS = 4,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned REQ_BITS   = 2
);
  logic [NUM_REQ-1:0]                                req_valid;
  logic [NUM_REQ-1:0][NUM_DIGITS-1:0][DIGIT_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]                                req_ready;
  logic                                              freeze;
  logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0]             data_out;
  logic [REQ_BITS-1:0]                               owner_out;
  logic                                              page_valid;

  modport master (
    output req_valid, req_data, freeze,
    input  req_ready, data_out, owner_out, page_valid
  );

  modport slave (
    input  req_valid, req_data, freeze,
    output req_ready, data_out, owner_out, page_valid
  );
endinterface

// File: rtl/display_page_arbiter.sv
// Round-robin arbiter sharing one seven-segment display between page requesters,
// holding each accepted page for at least DWELL_CYCLES cycles.
module display_page_arbiter #(
  parameter int unsigned           NUM_REQ      = 4,
  parameter int unsigned           DIGIT_BITS   = 4,
  parameter int unsigned           NUM_DIGITS   = 4,
  parameter int unsigned           DWELL_CYCLES = 100_000_000,
  parameter int unsigned           DWELL_BITS   = 27,
  parameter logic [DIGIT_BITS-1:0] IDLE_CODE    = 'hA,
  parameter int unsigned           REQ_BITS     = 2
) (
  input logic                    clk,
  input logic                    rst,
  display_page_arbiter_if.slave  bus
);

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  state_t                                r_state;
  state_t                                w_state_nxt;
  logic [DWELL_BITS-1:0]                 r_cnt;
  logic [DWELL_BITS-1:0]                 w_cnt_nxt;
  logic [REQ_BITS-1:0]                   r_rr_ptr;
  logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0] r_data;
  logic [REQ_BITS-1:0]                   r_owner;
  logic                                  r_page_valid;

  logic                                  w_open;
  logic                                  w_xfer;
  logic [REQ_BITS-1:0]                   w_win;
  logic [NUM_REQ-1:0]                    w_ready;
  int unsigned                           w_ptr;
  int unsigned                           w_dist;
  int unsigned                           w_best;

  // Window is also gated by rst so no ready is offered while reset is held
  assign w_open = rst && !bus.freeze && ((r_state == S_IDLE) || (r_cnt == '0));
  assign w_ptr  = 32'(r_rr_ptr);

  // Winner is the valid requester at the smallest rotational distance past rr_ptr
  always_comb begin
    w_xfer = 1'b0;
    w_win  = '0;
    w_best = NUM_REQ;
    w_dist = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + 2 * NUM_REQ - 1 - w_ptr) % NUM_REQ;
      if (w_open && bus.req_valid[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = REQ_BITS'(i);
        w_xfer = 1'b1;
      end
    end
    w_ready = '0;
    if (w_xfer) begin
      w_ready[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_xfer) begin
      w_state_nxt = S_SHOW;
      w_cnt_nxt   = DWELL_BITS'(DWELL_CYCLES - 1);
    end else if (r_state == S_SHOW) begin
      if (r_cnt == '0) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_cnt_nxt = r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr     <= REQ_BITS'(NUM_REQ - 1);
      r_data       <= {NUM_DIGITS{IDLE_CODE}};
      r_owner      <= '0;
      r_page_valid <= 1'b0;
    end else if (w_xfer) begin
      r_rr_ptr     <= w_win;
      r_data       <= bus.req_data[w_win];
      r_owner      <= w_win;
      r_page_valid <= 1'b1;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.data_out   = r_data;
  assign bus.owner_out  = r_owner;
  assign bus.page_valid = r_page_valid;

endmodule

// File: tb/tb_display_page_arbiter.sv
// Directed bench for display_page_arbiter with DWELL_CYCLES=4: per-cycle vector table
// plus a hand-written asynchronous reset sequence.
module tb_display_page_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_page_arbiter_if #(
    .NUM_REQ(4), .DIGIT_BITS(4), .NUM_DIGITS(4), .REQ_BITS(2)
  ) bus ();

  display_page_arbiter #(
    .NUM_REQ(4), .DIGIT_BITS(4), .NUM_DIGITS(4), .DWELL_CYCLES(4),
    .DWELL_BITS(3), .IDLE_CODE(4'hA), .REQ_BITS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Pages, digit 0 in the low nibble: r0 {5,6,7,8}, r1 {9,0,1,2}, r2 {1,2,3,4}, r3 {3,3,0,7}
  localparam logic [15:0] P0 = 16'h8765;
  localparam logic [15:0] P1 = 16'h2109;
  localparam logic [15:0] P2 = 16'h4321;
  localparam logic [15:0] P3 = 16'h7033;
  localparam logic [15:0] PI = 16'hAAAA;

  typedef struct {
    logic [3:0]  valid;
    logic        frz;
    logic [3:0]  ready;
    logic [15:0] data;
    logic [1:0]  owner;
    logic        pv;
  } vec_t;

  vec_t        vecs[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic void add(input logic [3:0] va, input logic fz, input logic [3:0] rd,
                              input logic [15:0] d, input logic [1:0] o, input logic pv,
                              input int unsigned reps);
    vec_t v;
    v.valid = va; v.frz = fz; v.ready = rd; v.data = d; v.owner = o; v.pv = pv;
    for (int unsigned k = 0; k < reps; k++) vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] rd, input logic [15:0] d,
                          input logic [1:0] o, input logic pv);
    chk({tag, " ready"}, 32'(bus.req_ready), 32'(rd));
    chk({tag, " data"},  32'(bus.data_out),  32'(d));
    chk({tag, " owner"}, 32'(bus.owner_out), 32'(o));
    chk({tag, " pv"},    32'(bus.page_valid), 32'(pv));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.freeze    = 1'b0;
    bus.req_data  = {P3, P2, P1, P0};

    // Reset state; a valid request during reset must see no ready
    @(negedge clk);
    bus.req_valid = 4'b0100;
    #1;
    chk_outs("reset", 4'b0000, PI, 2'd0, 1'b0);
    bus.req_valid = '0;
    rst = 1'b1;

    // Single request, then round robin 3,0,1,2 at 4-edge spacing
    add(4'b0100, 0, 4'b0100, PI, 2'd0, 0, 1);
    add(4'b0000, 0, 4'b0000, P2, 2'd2, 1, 3);
    add(4'b1111, 0, 4'b1000, P2, 2'd2, 1, 1);
    add(4'b1111, 0, 4'b0000, P3, 2'd3, 1, 3);
    add(4'b1111, 0, 4'b0001, P3, 2'd3, 1, 1);
    add(4'b1111, 0, 4'b0000, P0, 2'd0, 1, 3);
    add(4'b1111, 0, 4'b0010, P0, 2'd0, 1, 1);
    add(4'b1111, 0, 4'b0000, P1, 2'd1, 1, 3);
    add(4'b1111, 0, 4'b0100, P1, 2'd1, 1, 1);
    // Dwell enforcement: requester 1 appears 2 cycles after requester 2's transfer
    add(4'b0000, 0, 4'b0000, P2, 2'd2, 1, 1);
    add(4'b0010, 0, 4'b0000, P2, 2'd2, 1, 2);
    add(4'b0010, 0, 4'b0010, P2, 2'd2, 1, 1);
    // Idle hold
    add(4'b0000, 0, 4'b0000, P1, 2'd1, 1, 20);
    // Freeze with requesters 0 and 3, then release: rr_ptr=1 so 3 wins
    add(4'b1001, 1, 4'b0000, P1, 2'd1, 1, 10);
    add(4'b1001, 0, 4'b1000, P1, 2'd1, 1, 1);
    add(4'b0000, 0, 4'b0000, P3, 2'd3, 1, 1);

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.req_valid = vecs[i].valid;
      bus.freeze    = vecs[i].frz;
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].ready, vecs[i].data, vecs[i].owner, vecs[i].pv);
    end

    // Asynchronous reset pulse mid-SHOW, between clock edges
    @(negedge clk);
    bus.req_valid = 4'b0011;
    #1 rst = 1'b0;
    #1;
    chk_outs("arst", 4'b0000, PI, 2'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_rel ready", 32'(bus.req_ready), 32'(4'b0001));
    @(negedge clk);
    #1;
    chk_outs("arst_r0", 4'b0000, P0, 2'd0, 1'b1);
    for (int unsigned k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("arst_dwell%0d ready", k), 32'(bus.req_ready), 32'(4'b0000));
    end
    @(negedge clk);
    #1;
    chk("arst_r1 ready", 32'(bus.req_ready), 32'(4'b0010));
    @(negedge clk);
    #1;
    chk_outs("arst_r1", 4'b0000, P1, 2'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
